// File: rtl/vic_pot_pkg.sv
// Shared types and constants for the VIC pot sampler.
package vic_pot_pkg;
    typedef enum logic {DISCHARGE = 1'b0, CHARGE = 1'b1} pot_state_t;
    localparam int         CHARGE_CYCLES = 256;
    localparam logic [7:0] POT_FLOAT     = 8'hFF;
endpackage

// File: rtl/pot_channel.sv
// One pot channel: target snapshot, comparator latch, shadow and filtered
// output register.
module pot_channel
    import vic_pot_pkg::*;
#(
    parameter bit FILTER_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       snap,
    input  logic       charge_tick,
    input  logic       xfer,
    input  logic [7:0] cnt,
    input  logic [7:0] pd,
    input  logic       pd_valid,
    output logic [7:0] pot
);
    logic [7:0] target_q, target_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] out_q, out_d;
    logic       latched_q, latched_d;
    logic       hit;
    logic       adjacent;
    logic [7:0] final_val;

    always_comb begin
        target_d  = target_q;
        latched_d = latched_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        hit       = charge_tick && !latched_q && (cnt == target_q);
        if (snap) begin
            target_d  = pd_valid ? pd : POT_FLOAT;
            latched_d = 1'b0;
        end
        if (hit) begin
            shadow_d  = cnt;
            latched_d = 1'b1;
        end
        // The final tick may latch on the same edge as the transfer.
        final_val = hit ? cnt : (latched_q ? shadow_q : POT_FLOAT);
        adjacent  = ({1'b0, final_val} == {1'b0, out_q} + 9'd1) ||
                    ({1'b0, out_q} == {1'b0, final_val} + 9'd1);
        if (xfer) begin
            shadow_d = final_val;
            out_d    = (FILTER_EN && adjacent) ? out_q : final_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q  <= POT_FLOAT;
            latched_q <= 1'b0;
            shadow_q  <= POT_FLOAT;
            out_q     <= POT_FLOAT;
        end else begin
            target_q  <= target_d;
            latched_q <= latched_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
        end
    end

    assign pot = out_q;
endmodule

// File: rtl/pot_sampler.sv
// VIC POTX/POTY sampler: discharge/charge frame FSM driving two pot channels.
module pot_sampler
    import vic_pot_pkg::*;
#(
    parameter int DISCHARGE_CYCLES = 256,
    parameter bit FILTER_EN        = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [1:0][7:0] pd_in,
    input  logic [1:0]      pd_valid,
    output logic [7:0]      pot_x,
    output logic [7:0]      pot_y,
    output logic            busy,
    output logic            sample_done
);
    localparam logic [7:0] DIS_LAST = 8'(DISCHARGE_CYCLES - 1);
    localparam logic [7:0] CHG_LAST = 8'(CHARGE_CYCLES - 1);

    pot_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            snap, charge_tick, xfer;
    logic [1:0][7:0] pot_val;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap        = ce && (state_q == DISCHARGE) && (cnt_q == DIS_LAST);
        charge_tick = ce && (state_q == CHARGE);
        xfer        = charge_tick && (cnt_q == CHG_LAST);
        done_d      = xfer;
        if (snap) begin
            state_d = CHARGE;
            cnt_d   = 8'd0;
        end else if (xfer) begin
            state_d = DISCHARGE;
            cnt_d   = 8'd0;
        end else if (ce) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DISCHARGE;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        pot_channel #(.FILTER_EN(FILTER_EN)) u_ch (
            .clk         (clk),
            .reset       (reset),
            .snap        (snap),
            .charge_tick (charge_tick),
            .xfer        (xfer),
            .cnt         (cnt_q),
            .pd          (pd_in[i]),
            .pd_valid    (pd_valid[i]),
            .pot         (pot_val[i])
        );
    end

    assign pot_x       = pot_val[0];
    assign pot_y       = pot_val[1];
    assign busy        = (state_q == CHARGE);
    assign sample_done = done_q;
endmodule

// File: tb/tb_pot_sampler.sv
// Scoreboard bench for pot_sampler: filtered and unfiltered instances share stimulus.
module tb_pot_sampler;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;

    logic            clk, reset, ce;
    logic [1:0][7:0] pd_in;
    logic [1:0]      pd_valid;
    logic [7:0]      pot_x_f, pot_y_f, pot_x_n, pot_y_n;
    logic            busy_f, busy_n, done_f, done_n;

    int   checks = 0;
    int   failures = 0;
    int   ticks = 0;
    bit   ticked = 0;
    int   ce_mode = 0;
    int   ce_ph = 0;
    exp_t qf[$];
    exp_t qn[$];

    pot_sampler #(.DISCHARGE_CYCLES(256), .FILTER_EN(1'b1)) dut_f (
        .clk(clk), .reset(reset), .ce(ce), .pd_in(pd_in), .pd_valid(pd_valid),
        .pot_x(pot_x_f), .pot_y(pot_y_f), .busy(busy_f), .sample_done(done_f));

    pot_sampler #(.DISCHARGE_CYCLES(256), .FILTER_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .ce(ce), .pd_in(pd_in), .pd_valid(pd_valid),
        .pot_x(pot_x_n), .pot_y(pot_y_n), .busy(busy_n), .sample_done(done_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ce generator: 0 = tied high, 1 = one clk in three, 2 = held low.
    always @(negedge clk) begin
        case (ce_mode)
            0: ce = 1'b1;
            1: begin
                ce    = (ce_ph == 0);
                ce_ph = (ce_ph + 1) % 3;
            end
            default: ce = 1'b0;
        endcase
    end

    // Reference ce-tick counter since the last reset.
    always @(posedge clk) begin
        if (reset) ticks <= 0;
        else if (ce) ticks <= ticks + 1;
        ticked <= ce && !reset;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, ticks);
        end
    endtask

    // Monitor: timing of busy/sample_done and scoreboard pops on each sample.
    always @(negedge clk) begin
        logic exp_done;
        exp_t e;
        exp_done = ticked && (ticks % 512 == 0);
        chk("done_f", {7'd0, done_f}, {7'd0, exp_done});
        chk("done_n", {7'd0, done_n}, {7'd0, exp_done});
        chk("busy_f", {7'd0, busy_f}, {7'd0, (ticks % 512) >= 256});
        chk("busy_n", {7'd0, busy_n}, {7'd0, (ticks % 512) >= 256});
        if (done_f) begin
            if (qf.size() == 0) chk("unexpected_sample_f", 8'd1, 8'd0);
            else begin
                e = qf.pop_front();
                chk("pot_x_f", pot_x_f, e.x);
                chk("pot_y_f", pot_y_f, e.y);
            end
        end
        if (done_n) begin
            if (qn.size() == 0) chk("unexpected_sample_n", 8'd1, 8'd0);
            else begin
                e = qn.pop_front();
                chk("pot_x_n", pot_x_n, e.x);
                chk("pot_y_n", pot_y_n, e.y);
            end
        end
    end

    task automatic wait_ticks(input int n);
        int tgt;
        int guard;
        tgt = ticks + n;
        guard = 0;
        while (ticks < tgt && guard < 4 * n + 20) begin
            @(negedge clk);
            guard++;
        end
        if (ticks < tgt) chk("tick_timeout", 8'd1, 8'd0);
    endtask

    task automatic push(input logic [7:0] fx, input logic [7:0] fy,
                        input logic [7:0] nx, input logic [7:0] ny);
        qf.push_back({fx, fy});
        qn.push_back({nx, ny});
    endtask

    task automatic frame(input logic [7:0] px, input logic [7:0] py, input logic [1:0] v,
                         input logic [7:0] fx, input logic [7:0] fy,
                         input logic [7:0] nx, input logic [7:0] ny);
        pd_in[0] = px;
        pd_in[1] = py;
        pd_valid = v;
        push(fx, fy, nx, ny);
        wait_ticks(512);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pot_x_f"}, pot_x_f, 8'hFF);
        chk({tag, "_pot_y_f"}, pot_y_f, 8'hFF);
        chk({tag, "_pot_x_n"}, pot_x_n, 8'hFF);
        chk({tag, "_pot_y_n"}, pot_y_n, 8'hFF);
    endtask

    initial begin
        logic [7:0] hold_x;
        reset    = 1'b1;
        ce       = 1'b1;
        pd_in    = '0;
        pd_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        // Basic conversion, first sample after 512 ticks.
        frame(8'h80, 8'h00, 2'b11, 8'h80, 8'h00, 8'h80, 8'h00);
        // POTY unassigned floats to FF; POTX tracks.
        frame(8'h33, 8'h40, 2'b01, 8'h33, 8'hFF, 8'h33, 8'hFF);
        frame(8'h90, 8'h40, 2'b01, 8'h90, 8'hFF, 8'h90, 8'hFF);
        frame(8'h07, 8'h40, 2'b01, 8'h07, 8'hFF, 8'h07, 8'hFF);

        // Change during CHARGE ignored until next snapshot.
        pd_in[0] = 8'h10;
        pd_in[1] = 8'hC0;
        pd_valid = 2'b11;
        push(8'h10, 8'hC0, 8'h10, 8'hC0);
        wait_ticks(261);
        pd_in[0] = 8'hF0;
        wait_ticks(251);
        frame(8'hF0, 8'hC0, 2'b11, 8'hF0, 8'hC0, 8'hF0, 8'hC0);

        // Hysteresis.
        frame(8'h50, 8'hC0, 2'b11, 8'h50, 8'hC0, 8'h50, 8'hC0);
        frame(8'h51, 8'hC0, 2'b11, 8'h50, 8'hC0, 8'h51, 8'hC0);
        frame(8'h4F, 8'hC0, 2'b11, 8'h50, 8'hC0, 8'h4F, 8'hC0);
        frame(8'h53, 8'hC0, 2'b11, 8'h53, 8'hC0, 8'h53, 8'hC0);

        // Reset at CHARGE tick 100 aborts the frame.
        pd_in[0] = 8'h20;
        pd_in[1] = 8'h20;
        wait_ticks(356);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b0;
        push(8'h20, 8'h20, 8'h20, 8'h20);
        wait_ticks(512);

        // 1-in-3 ce, including a stretch with ce held low mid-frame.
        ce_mode = 1;
        frame(8'h21, 8'h7F, 2'b11, 8'h20, 8'h7F, 8'h21, 8'h7F);
        pd_in[0] = 8'hA5;
        push(8'hA5, 8'h7F, 8'hA5, 8'h7F);
        wait_ticks(300);
        ce_mode = 2;
        hold_x = pot_x_f;
        repeat (20) @(negedge clk);
        chk("freeze_pot_x_f", pot_x_f, hold_x);
        ce_mode = 1;
        wait_ticks(212);
        repeat (4) @(negedge clk);

        chk("pending_f", 8'(qf.size()), 8'd0);
        chk("pending_n", 8'(qn.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pot_sampler.md
Name: pot_sampler

Overview:
- Sits directly downstream of the paddle chooser.
- Converts two 8-bit paddle positions (POT X / POT Y channels) into the values the VIC POTX/POTY registers return.
- Emulates the VIC 512-cycle pot measurement frame: discharge window, then a charge/count window with a per-channel comparator latch.
- Results are double-buffered so the CPU only ever sees complete samples. An optional jitter filter suppresses ±1 LSB flicker from analog sticks.

Parameters:
- DISCHARGE_CYCLES, 256, length of the discharge phase in ce ticks (power of two, 2..256).
- FILTER_EN, 1, enables the ±1 LSB hysteresis on output update.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  phi2 cycle enable; all frame timing advances only on clk edges with ce=1
- pd_in  in  2x8  paddle position per channel ([0]=POTX, [1]=POTY); 0=min resistance
- pd_valid  in  2  channel has an assigned paddle source
- pot_x  out  8  POTX register value
- pot_y  out  8  POTY register value
- busy  out  1  high during the CHARGE phase
- sample_done  out  1  one-clk pulse when pot_x/pot_y are updated

Behaviour:
- Reset values: pot_x=pot_y=8'hFF, busy=0, sample_done=0, state=DISCHARGE, phase counter=0, shadows=8'hFF, targets=8'hFF, latched flags=0.
- Reset takes priority over ce. Reset mid-frame aborts the frame; no transfer occurs.
- FSM states: DISCHARGE, CHARGE. The phase counter advances only on ce.
- DISCHARGE:
  - Counter runs 0..DISCHARGE_CYCLES-1.
  - On the ce tick at DISCHARGE_CYCLES-1: snapshot each target (pd_in[i] if pd_valid[i], else 8'hFF), clear both latched flags, counter←0, state←CHARGE.
- CHARGE:
  - 8-bit count c runs 0..255; busy=1 for the whole phase.
  - Each ce tick, for each channel i not yet latched: if c == target[i], then shadow[i]←c and latched[i]←1.
  - Target 0 latches on the first CHARGE tick. Target 255 latches on the last tick (c=255).
  - pd_in changes during CHARGE are ignored; the snapshot governs.
  - On the ce tick at c=255: go to DISCHARGE, counter←0, and perform the transfer on the same edge.
- Transfer (same edge as the final CHARGE tick):
  - Any channel still unlatched loads 8'hFF into shadow first. This cannot happen with 8-bit targets, but it is required for robustness.
  - For each channel: if FILTER_EN and |shadow−current output| == 1, hold the current output. Otherwise the output takes shadow.
  - The compare is unsigned 9-bit; 0 and 255 are not adjacent, so there is no wrap.
- sample_done: pulses for exactly one clk on the transfer edge, regardless of whether the values changed.
- Frame and latency:
  - Frame length = DISCHARGE_CYCLES+256 ce ticks.
  - A value is sampled at the DISCHARGE→CHARGE edge and appears on pot_x/pot_y 256 ce ticks later, visible the clk after the transfer edge.
- Invalid channel: target 8'hFF, so the output converges to 8'hFF (floating pot).
- ce held low: all state frozen, outputs stable, sample_done stays 0.

Decomposition:
- Shared package vic_pot_pkg:
  - typedef pot_state_t {DISCHARGE, CHARGE}
  - localparam CHARGE_CYCLES=256
  - localparam POT_FLOAT=8'hFF
- One natural sub-module, pot_channel, instantiated twice. It contains:
  - target snapshot
  - comparator latch
  - shadow register
  - filter and output register
- The top level holds the FSM, the counter and sample_done.

Test Plan:
- Reset, then 600 ce ticks with pd_in={8'h00,8'h80}, pd_valid=2'b11 → first sample_done after exactly 512 ce ticks; pot_x=8'h80, pot_y=8'h00; busy high for ticks 256..511.
- pd_valid=2'b01, pd_in[1]=8'h40 → pot_y stays 8'hFF across three frames; pot_x tracks pd_in[0].
- Set pd_in[0]=8'h10 during DISCHARGE, change it to 8'hF0 at CHARGE tick 5 → that frame pot_x=8'h10; the next frame pot_x=8'hF0.
- FILTER_EN=1 with pot_x at 8'h50: successive samples 8'h51, 8'h4F, 8'h53 → pot_x 8'h50, 8'h50, 8'h53. With FILTER_EN=0 → 8'h51, 8'h4F, 8'h53.
- Assert reset at CHARGE tick 100 with targets {8'h20,8'h20} → pot_x=pot_y=8'hFF, no sample_done, and the next sample_done comes 512 ce ticks after reset release.
- Toggle ce at a 1-in-3 duty → identical output sequence and pulse count (per ce tick) as with ce tied high; sample_done remains a single clk wide.
